bin2bcd_seq_disp: RTL and testbench

BIN2BCD_SEQ_DISP -- requirements
Module: bin2bcd_seq_disp

---
 rtl/bin2bcd_seq_disp.sv | 121 ++++++++++++
 tb/tb_bin2bcd_seq_disp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_disp.sv
// Sequential binary-to-BCD (shift-add-3) or hex passthrough with seven-segment decode.
// Optional macro BIN2BCD_BLANK_EN blanks leading-zero digits on Seg.
module bin2bcd_seq_disp #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  Start,
  input  logic                  Base,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Ovf,
  output logic [4*DIGITS-1:0]   Digits,
  output logic [7*DIGITS-1:0]   Seg
);

  // Accumulator holds enough digits for any WIDTH-bit value, and at least DIGITS
  localparam int ND0 = WIDTH / 3 + 1;
  localparam int NDI = (ND0 > DIGITS) ? ND0 : DIGITS;
  localparam int BW  = 4 * NDI;
  localparam int WX  = (WIDTH > 4 * DIGITS) ? WIDTH : 4 * DIGITS;
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    acc, acc_adj, acc_nxt;
  logic [BW:0]      acc_wide;
  logic [CW-1:0]    cnt;
  logic [WX-1:0]    hex_ext;
  logic             take, last, hex_ovf, dec_ovf;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    take      = Start && (state != CONV);
    last      = (state == CONV) && (cnt == CW'(WIDTH - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = Base ? CONV : DONE;
      CONV:    if (last) state_nxt = DONE;
      DONE:    state_nxt = take ? (Base ? CONV : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
    Busy = (state == CONV);
    Done = (state == DONE);
  end

  always_comb begin
    acc_adj = '0;
    for (int unsigned k = 0; k < NDI; k++)
      acc_adj[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
    acc_wide = {acc_adj, sh[WIDTH-1]};
    acc_nxt  = acc_wide[BW-1:0];
    dec_ovf  = (acc_wide >> (4 * DIGITS)) != '0;
    hex_ext  = WX'(Bin);
    hex_ovf  = (hex_ext >> (4 * DIGITS)) != '0;
  end

  // Hex results are latched at capture; decimal results on the final step.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state  <= IDLE;
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      Digits <= '0;
      Ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        sh  <= Bin;
        acc <= '0;
        cnt <= '0;
        if (!Base) begin
          Digits <= hex_ext[4*DIGITS-1:0];
          Ovf    <= hex_ovf;
        end
      end else if (state == CONV) begin
        sh  <= sh << 1;
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          Digits <= acc_nxt[4*DIGITS-1:0];
          Ovf    <= dec_ovf;
        end
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic lz;
  always_comb begin
    Seg = '0;
    lz  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      int unsigned k;
      k  = DIGITS - 1 - i;
      lz = lz && (Digits[4*k +: 4] == 4'd0);
      Seg[7*k +: 7] = (lz && k != 0) ? 7'h7F : glyph(Digits[4*k +: 4]);
    end
  end
`else
  always_comb begin
    Seg = '0;
    for (int unsigned k = 0; k < DIGITS; k++)
      Seg[7*k +: 7] = glyph(Digits[4*k +: 4]);
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq_disp.sv
// Directed self-checking bench for bin2bcd_seq_disp (WIDTH=16; DIGITS=5 and DIGITS=4 instances).
module tb_bin2bcd_seq_disp;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Clrn, Start, Base;
  logic [15:0] Bin;
  logic        Busy, Done, Ovf, Busy4, Done4, Ovf4;
  logic [19:0] Digits;
  logic [15:0] Digits4;
  logic [34:0] Seg;
  logic [27:0] Seg4;

  int ntests = 0;
  int nfail  = 0;

  bin2bcd_seq_disp #(.WIDTH(16), .DIGITS(5)) dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .Base(Base), .Bin(Bin),
    .Busy(Busy), .Done(Done), .Ovf(Ovf), .Digits(Digits), .Seg(Seg)
  );

  bin2bcd_seq_disp #(.WIDTH(16), .DIGITS(4)) dut4 (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .Base(Base), .Bin(Bin),
    .Busy(Busy4), .Done(Done4), .Ovf(Ovf4), .Digits(Digits4), .Seg(Seg4)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input logic b, input logic [15:0] v);
    Start = 1'b1; Base = b; Bin = v;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busyc, output int held_bad);
    logic [19:0] prev;
    prev = Digits; lat = 1; busyc = 0; held_bad = 0;
    while (!Done && lat < 40) begin
      if (Busy) busyc++;
      if (Digits !== prev) held_bad++;
      tick();
      lat++;
    end
  endtask

  int lat, busyc, held, dsum;

  initial begin
    Clrn = 1'b0; Start = 1'b0; Base = 1'b0; Bin = '0;
    tick(); tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_digits", Digits, 0);
    chk("rst_seg", Seg, BLANK ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40} : {5{7'h40}});
    Clrn = 1'b1;
    tick();

    // decimal 65535
    go(1'b1, 16'd65535);
    wait_done(lat, busyc, held);
    chk("dec_lat", lat, 17);
    chk("dec_busy_cycles", busyc, 16);
    chk("dec_hold", held, 0);
    chk("dec_digits", Digits, 20'h65535);
    chk("dec_ovf", Ovf, 0);
    chk("dec_seg", Seg, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    tick();
    chk("done_one_cycle", Done, 0);
    chk("idle_busy", Busy, 0);

    // hex passthrough 00A7
    go(1'b0, 16'h00A7);
    chk("hex_done_n1", Done, 1);
    chk("hex_busy", Busy, 0);
    chk("hex_digits", Digits, 20'h000A7);
    chk("hex_seg0", Seg[6:0], 7'h78);
    chk("hex_seg1", Seg[13:7], 7'h08);
    chk("hex_seg", Seg, BLANK ? {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h78}
                              : {7'h40, 7'h40, 7'h40, 7'h08, 7'h78});
    chk("hex_ovf", Ovf, 0);
    tick();
    chk("hex_busy_after", Busy, 0);

    // DIGITS=4 overflow behaviour
    go(1'b1, 16'd12345);
    wait_done(lat, busyc, held);
    chk("d4_dec_done", Done4, 1);
    chk("d4_dec_digits", Digits4, 16'h2345);
    chk("d4_dec_ovf", Ovf4, 1);
    chk("d5_dec_digits", Digits, 20'h12345);
    chk("d5_dec_ovf", Ovf, 0);
    tick();
    go(1'b0, 16'h1234);
    chk("d4_hex_digits", Digits4, 16'h1234);
    chk("d4_hex_ovf", Ovf4, 0);
    tick();

    // reset at N+8 of a decimal conversion
    go(1'b1, 16'd4321);
    repeat (7) tick();
    chk("pre_rst_busy", Busy, 1);
    Clrn = 1'b0;
    tick();
    Clrn = 1'b1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_digits", Digits, 0);
    dsum = 0;
    repeat (20) begin
      dsum += int'(Done);
      tick();
    end
    chk("abort_no_done", dsum, 0);
    go(1'b1, 16'd1234);
    wait_done(lat, busyc, held);
    chk("post_rst_lat", lat, 17);
    chk("post_rst_digits", Digits, 20'h01234);

    // Start during CONV ignored, then back-to-back from DONE
    tick();
    go(1'b1, 16'd100);
    repeat (4) tick();
    Start = 1'b1; Base = 1'b0; Bin = 16'd999;
    tick();
    Start = 1'b0;
    wait_done(lat, busyc, held);
    chk("ign_lat", lat, 12);
    chk("ign_digits", Digits, 20'h00100);
    go(1'b1, 16'd777);
    wait_done(lat, busyc, held);
    chk("b2b_lat", lat, 17);
    chk("b2b_busy_cycles", busyc, 16);
    chk("b2b_digits", Digits, 20'h00777);

    // blanking cases (glyphs always present in the default build)
    tick();
    go(1'b1, 16'd42);
    wait_done(lat, busyc, held);
    chk("seg_42", Seg, BLANK ? {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}
                             : {7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
    chk("digits_42", Digits, 20'h00042);
    tick();
    go(1'b1, 16'd0);
    wait_done(lat, busyc, held);
    chk("seg_zero", Seg, BLANK ? {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40} : {5{7'h40}});
    chk("digits_zero", Digits, 20'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
